// File: rtl/mvm_scheduler.sv
// mvm_scheduler: round-robin arbiter sharing one mvm engine among NUM_REQ requesters,
// with registered operands and a BUSY watchdog that aborts and clears the engine.
module mvm_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int MATRIX_ROWS = 6,
  parameter int SHARED_DIM = 3,
  parameter int WIDTH = 8,
  parameter int TIMEOUT = 32,
  localparam int MW = MATRIX_ROWS * SHARED_DIM * WIDTH,
  localparam int VW = SHARED_DIM * WIDTH,
  localparam int RW = MW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*MW-1:0] req_matrix,
  input  logic [NUM_REQ*VW-1:0] req_vector,
  output logic [NUM_REQ-1:0]    ack,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [RW-1:0]         resp_data,
  output logic                  resp_err,
  output logic                  busy,
  output logic                  eng_start,
  output logic [MW-1:0]         eng_matrix,
  output logic [VW-1:0]         eng_vector,
  output logic                  eng_clear,
  input  logic                  eng_done,
  input  logic [RW-1:0]         eng_result
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, BUSY = 2'd2, RESPOND = 2'd3;
  logic [1:0] state;
  logic [OW-1:0] owner, rr_ptr, winner;
  logic [TW-1:0] timer;
  logic [NUM_REQ-1:0] owner_hot, winner_hot;
  // Scan downward so the nearest set bit after rr_ptr is the last one written.
  always_comb begin
    winner = rr_ptr;
    for (int k = NUM_REQ; k >= 1; k--)
      if (req[(int'(rr_ptr) + k) % NUM_REQ]) winner = OW'((int'(rr_ptr) + k) % NUM_REQ);
  end
  assign owner_hot = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
  assign winner_hot = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      owner <= '0;
      rr_ptr <= OW'(NUM_REQ - 1);
      timer <= '0;
      ack <= '0;
      resp_valid <= '0;
      resp_data <= '0;
      resp_err <= 1'b0;
      eng_start <= 1'b0;
      eng_matrix <= '0;
      eng_vector <= '0;
      eng_clear <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          owner <= winner;
          eng_matrix <= req_matrix[winner*MW +: MW];
          eng_vector <= req_vector[winner*VW +: VW];
          ack <= winner_hot;
          eng_start <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          ack <= '0;
          eng_start <= 1'b0;
          timer <= '0;
          state <= BUSY;
        end
        BUSY: begin
          timer <= timer + 1'b1;
          if (eng_done) begin
            resp_data <= eng_result;
            resp_err <= 1'b0;
            resp_valid <= owner_hot;
            state <= RESPOND;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            resp_data <= '0;
            resp_err <= 1'b1;
            resp_valid <= owner_hot;
            eng_clear <= 1'b1;
            state <= RESPOND;
          end
        end
        default: begin
          rr_ptr <= owner;
          resp_valid <= '0;
          resp_err <= 1'b0;
          eng_clear <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
